// File: rtl/tlrot_frag_pkg.sv
// rtl/tlrot_frag_pkg.sv - shared opcodes, FSM states, captured-request type and request checks
package tlrot_frag_pkg;

    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } frag_state_e;

    // Width-independent part of the captured A request; source and address
    // are parameterised and so live in separate registers in the top.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [7:0]  mask;
        logic [63:0] data;
    } frag_req_t;

    function automatic logic is_bad_opcode(input logic [2:0] opcode);
        return !(opcode == PutFullData || opcode == PutPartialData || opcode == Get);
    endfunction

    // Sizes above 3 cannot be served by a 64-bit bus and count as misaligned.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [2:0] size);
        case (size)
            3'd0:    return 1'b0;
            3'd1:    return addr_lo[0];
            3'd2:    return |addr_lo[1:0];
            3'd3:    return |addr_lo[2:0];
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/tlrot_frag_lane.sv
// rtl/tlrot_frag_lane.sv - combinational beat formation (address, size, mask and data lane select)
//
// Ports:
//   address_i, size_i, mask_i, data_i : captured upstream request fields
//   beat_i                            : current beat index of an 8-byte access
//   half_o                            : 32-bit half of the 64-bit bus used by this beat
//   address_o, size_o, mask_o, data_o : downstream beat fields
module tlrot_frag_lane #(
    parameter int AddrW = 32
) (
    input  logic [AddrW-1:0] address_i,
    input  logic [2:0]       size_i,
    input  logic [7:0]       mask_i,
    input  logic [63:0]      data_i,
    input  logic             beat_i,
    output logic             half_o,
    output logic [AddrW-1:0] address_o,
    output logic [1:0]       size_o,
    output logic [3:0]       mask_o,
    output logic [31:0]      data_o
);

    logic wide;

    assign wide = (size_i == 3'd3);

    // 8-byte accesses walk both halves in order; narrow ones stay in the
    // half their address selects.
    assign half_o    = wide ? beat_i : address_i[2];
    // Wide beats are re-based on the 8-byte boundary: {addr[AddrW-1:3], beat, 2'b00}.
    assign address_o = wide ? {address_i[AddrW-1:3], beat_i, 2'b00} : address_i;
    assign size_o    = wide ? 2'd2 : size_i[1:0];
    assign mask_o    = half_o ? mask_i[7:4]  : mask_i[3:0];
    assign data_o    = half_o ? data_i[63:32] : data_i[31:0];

endmodule

// File: rtl/tlrot_tl_fragmenter.sv
// rtl/tlrot_tl_fragmenter.sv - 64-bit to 32-bit TL-UL request fragmenter with response merge
//
// Optional feature macro: TLROT_FRAG_ALIGN_CHECK_EN (reject misaligned or
// unknown-opcode requests in IDLE with a denied response, no downstream beat).
//
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   up_a_*          : upstream 64-bit A channel (request in)
//   up_d_*          : upstream 64-bit D channel (merged response out)
//   dn_a_*          : downstream 32-bit A channel (beats out)
//   dn_d_*          : downstream 32-bit D channel (beat responses in)
module tlrot_tl_fragmenter
    import tlrot_frag_pkg::*;
#(
    parameter int SourceW = 8,
    parameter int AddrW   = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               up_a_valid,
    output logic               up_a_ready,
    input  logic [2:0]         up_a_opcode,
    input  logic [2:0]         up_a_param,
    input  logic [2:0]         up_a_size,
    input  logic [SourceW-1:0] up_a_source,
    input  logic [AddrW-1:0]   up_a_address,
    input  logic [7:0]         up_a_mask,
    input  logic [63:0]        up_a_data,

    output logic               up_d_valid,
    input  logic               up_d_ready,
    output logic [2:0]         up_d_opcode,
    output logic [1:0]         up_d_size,
    output logic [SourceW-1:0] up_d_source,
    output logic [63:0]        up_d_data,
    output logic               up_d_denied,

    output logic               dn_a_valid,
    input  logic               dn_a_ready,
    output logic [2:0]         dn_a_opcode,
    output logic [2:0]         dn_a_param,
    output logic [1:0]         dn_a_size,
    output logic [SourceW-1:0] dn_a_source,
    output logic [AddrW-1:0]   dn_a_address,
    output logic [3:0]         dn_a_mask,
    output logic [31:0]        dn_a_data,

    input  logic               dn_d_valid,
    output logic               dn_d_ready,
    input  logic [2:0]         dn_d_opcode,
    input  logic [31:0]        dn_d_data,
    input  logic               dn_d_error
);

    frag_state_e        state_q, state_d;
    frag_req_t          req_q, req_d;
    logic [SourceW-1:0] source_q, source_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic               beat_q, beat_d;
    logic [1:0]         nbeats_q, nbeats_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               denied_q, denied_d;
    logic [2:0]         d_opcode_q, d_opcode_d;

    logic               half;

    tlrot_frag_lane #(.AddrW(AddrW)) u_lane (
        .address_i (addr_q),
        .size_i    (req_q.size),
        .mask_i    (req_q.mask),
        .data_i    (req_q.data),
        .beat_i    (beat_q),
        .half_o    (half),
        .address_o (dn_a_address),
        .size_o    (dn_a_size),
        .mask_o    (dn_a_mask),
        .data_o    (dn_a_data)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        source_d   = source_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        nbeats_d   = nbeats_q;
        rdata_d    = rdata_q;
        denied_d   = denied_q;
        d_opcode_d = d_opcode_q;

        case (state_q)
            IDLE: begin
                if (up_a_valid) begin
                    req_d.opcode = up_a_opcode;
                    req_d.param  = up_a_param;
                    req_d.size   = up_a_size;
                    req_d.mask   = up_a_mask;
                    req_d.data   = up_a_data;
                    source_d     = up_a_source;
                    addr_d       = up_a_address;
                    beat_d       = 1'b0;
                    nbeats_d     = (up_a_size == 3'd3) ? 2'd2 : 2'd1;
                    rdata_d      = '0;
                    denied_d     = 1'b0;
                    d_opcode_d   = AccessAck;
                    state_d      = ISSUE;
`ifdef TLROT_FRAG_ALIGN_CHECK_EN
                    if (is_misaligned(up_a_address[2:0], up_a_size) ||
                        is_bad_opcode(up_a_opcode)) begin
                        denied_d   = 1'b1;
                        d_opcode_d = (up_a_opcode == Get) ? AccessAckData : AccessAck;
                        state_d    = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                if (dn_a_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dn_d_valid) begin
                    // The other half keeps the zero loaded at acceptance, so
                    // narrow reads return 0 in the unused lanes.
                    if (half) begin
                        rdata_d[63:32] = dn_d_data;
                    end else begin
                        rdata_d[31:0] = dn_d_data;
                    end
                    denied_d   = denied_q | dn_d_error;
                    d_opcode_d = dn_d_opcode;
                    if ({1'b0, beat_q} == nbeats_q - 2'd1) begin
                        state_d = RESP;
                    end else begin
                        beat_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            RESP: begin
                if (up_d_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            req_q      <= '0;
            source_q   <= '0;
            addr_q     <= '0;
            beat_q     <= 1'b0;
            nbeats_q   <= 2'd0;
            rdata_q    <= '0;
            denied_q   <= 1'b0;
            d_opcode_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            source_q   <= source_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            nbeats_q   <= nbeats_d;
            rdata_q    <= rdata_d;
            denied_q   <= denied_d;
            d_opcode_q <= d_opcode_d;
        end
    end

    assign up_a_ready  = (state_q == IDLE);
    assign dn_a_valid  = (state_q == ISSUE);
    assign dn_d_ready  = (state_q == WAIT);
    assign up_d_valid  = (state_q == RESP);

    assign dn_a_opcode = req_q.opcode;
    assign dn_a_param  = req_q.param;
    assign dn_a_source = source_q;

    assign up_d_opcode = d_opcode_q;
    assign up_d_size   = req_q.size[1:0];
    assign up_d_source = source_q;
    assign up_d_data   = rdata_q;
    assign up_d_denied = denied_q;

endmodule

// File: tb/tb_tlrot_tl_fragmenter.sv
// tb/tb_tlrot_tl_fragmenter.sv - self-checking bench for tlrot_tl_fragmenter
module tb_tlrot_tl_fragmenter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        up_a_valid;
    logic        up_a_ready;
    logic [2:0]  up_a_opcode;
    logic [2:0]  up_a_param;
    logic [2:0]  up_a_size;
    logic [7:0]  up_a_source;
    logic [31:0] up_a_address;
    logic [7:0]  up_a_mask;
    logic [63:0] up_a_data;
    logic        up_d_valid;
    logic        up_d_ready;
    logic [2:0]  up_d_opcode;
    logic [1:0]  up_d_size;
    logic [7:0]  up_d_source;
    logic [63:0] up_d_data;
    logic        up_d_denied;
    logic        dn_a_valid;
    logic        dn_a_ready;
    logic [2:0]  dn_a_opcode;
    logic [2:0]  dn_a_param;
    logic [1:0]  dn_a_size;
    logic [7:0]  dn_a_source;
    logic [31:0] dn_a_address;
    logic [3:0]  dn_a_mask;
    logic [31:0] dn_a_data;
    logic        dn_d_valid;
    logic        dn_d_ready;
    logic [2:0]  dn_d_opcode;
    logic [31:0] dn_d_data;
    logic        dn_d_error;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    tlrot_tl_fragmenter #(.SourceW(8), .AddrW(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .up_a_valid   (up_a_valid),
        .up_a_ready   (up_a_ready),
        .up_a_opcode  (up_a_opcode),
        .up_a_param   (up_a_param),
        .up_a_size    (up_a_size),
        .up_a_source  (up_a_source),
        .up_a_address (up_a_address),
        .up_a_mask    (up_a_mask),
        .up_a_data    (up_a_data),
        .up_d_valid   (up_d_valid),
        .up_d_ready   (up_d_ready),
        .up_d_opcode  (up_d_opcode),
        .up_d_size    (up_d_size),
        .up_d_source  (up_d_source),
        .up_d_data    (up_d_data),
        .up_d_denied  (up_d_denied),
        .dn_a_valid   (dn_a_valid),
        .dn_a_ready   (dn_a_ready),
        .dn_a_opcode  (dn_a_opcode),
        .dn_a_param   (dn_a_param),
        .dn_a_size    (dn_a_size),
        .dn_a_source  (dn_a_source),
        .dn_a_address (dn_a_address),
        .dn_a_mask    (dn_a_mask),
        .dn_a_data    (dn_a_data),
        .dn_d_valid   (dn_d_valid),
        .dn_d_ready   (dn_d_ready),
        .dn_d_opcode  (dn_d_opcode),
        .dn_d_data    (dn_d_data),
        .dn_d_error   (dn_d_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_up_a_ready"}, 64'(up_a_ready), 64'd1);
        chk({tag, "_up_d_valid"}, 64'(up_d_valid), 64'd0);
        chk({tag, "_dn_a_valid"}, 64'(dn_a_valid), 64'd0);
        chk({tag, "_dn_d_ready"}, 64'(dn_d_ready), 64'd0);
    endtask

    // Reference: byte address of an 8-byte access's beat b is the 8-byte
    // boundary plus 4*b; narrow accesses keep their address in half addr[2].
    task automatic chk_beat(input string tag, input logic [2:0] op, input logic [2:0] prm,
                            input logic [2:0] size, input logic [7:0] src, input logic [31:0] addr,
                            input logic [7:0] mask, input logic [63:0] data, input int b);
        int          h;
        logic [31:0] e_addr;
        logic [1:0]  e_size;
        if (size == 3'd3) begin
            h      = b;
            e_addr = (addr / 8) * 8 + 32'(4 * b);
            e_size = 2'd2;
        end else begin
            h      = int'(addr[2]);
            e_addr = addr;
            e_size = size[1:0];
        end
        chk({tag, "_valid"},  64'(dn_a_valid),   64'd1);
        chk({tag, "_addr"},   64'(dn_a_address), 64'(e_addr));
        chk({tag, "_size"},   64'(dn_a_size),    64'(e_size));
        chk({tag, "_mask"},   64'(dn_a_mask),    64'((mask >> (4 * h)) & 8'hF));
        chk({tag, "_data"},   64'(dn_a_data),    (data >> (32 * h)) & 64'hFFFF_FFFF);
        chk({tag, "_opcode"}, 64'(dn_a_opcode),  64'(op));
        chk({tag, "_param"},  64'(dn_a_param),   64'(prm));
        chk({tag, "_source"}, 64'(dn_a_source),  64'(src));
        chk({tag, "_upready"}, 64'(up_a_ready),  64'd0);
    endtask

    task automatic chk_resp(input string tag, input logic [2:0] op, input logic [2:0] size,
                            input logic [7:0] src, input logic [63:0] e_data, input logic e_den);
        chk({tag, "_valid"},   64'(up_d_valid),  64'd1);
        chk({tag, "_opcode"},  64'(up_d_opcode), 64'(op));
        chk({tag, "_size"},    64'(up_d_size),   64'(size[1:0]));
        chk({tag, "_source"},  64'(up_d_source), 64'(src));
        chk({tag, "_data"},    up_d_data,        e_data);
        chk({tag, "_denied"},  64'(up_d_denied), 64'(e_den));
        chk({tag, "_upready"}, 64'(up_a_ready),  64'd0);
    endtask

    // One full upstream transaction. Called just after a rising edge.
    task automatic run_txn(input string tag, input logic [2:0] op, input logic [2:0] prm,
                           input logic [2:0] size, input logic [7:0] src, input logic [31:0] addr,
                           input logic [7:0] mask, input logic [63:0] data,
                           input logic [31:0] rd0, input logic [31:0] rd1,
                           input logic err0, input logic err1, input int a_stall, input int d_stall);
        int          nb;
        int          n;
        bit          rejected;
        logic [31:0] rd [2];
        logic        er [2];
        logic [2:0]  dop [2];
        logic [63:0] e_data;
        logic        e_den;
        logic [2:0]  e_op;

        rd[0] = rd0; rd[1] = rd1; er[0] = err0; er[1] = err1;
        nb = (size == 3'd3) ? 2 : 1;
        rejected = 1'b0;
`ifdef TLROT_FRAG_ALIGN_CHECK_EN
        rejected = ((addr % (32'd1 << size)) != 0) || !(op inside {3'd0, 3'd1, 3'd4});
`endif
        if (rejected) nb = 0;
        // Only the last beat's response opcode should reach upstream.
        for (int b = 0; b < 2; b++) begin
            dop[b] = (b == nb - 1) ? ((op == 3'd4) ? 3'd1 : 3'd0) : 3'($urandom_range(0, 7));
        end

        if (rejected) begin
            e_data = 64'd0;
            e_den  = 1'b1;
            e_op   = (op == 3'd4) ? 3'd1 : 3'd0;
        end else begin
            e_den = err0 | ((nb == 2) ? err1 : 1'b0);
            e_op  = dop[nb - 1];
            if (nb == 2)        e_data = {rd1, rd0};
            else if (addr[2])   e_data = {rd0, 32'd0};
            else                e_data = {32'd0, rd0};
        end

        up_a_opcode  = op;
        up_a_param   = prm;
        up_a_size    = size;
        up_a_source  = src;
        up_a_address = addr;
        up_a_mask    = mask;
        up_a_data    = data;
        up_a_valid   = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!up_a_ready && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_accept"}, 64'(up_a_ready), 64'd1);
        @(posedge clk_i);
        #1;
        up_a_valid = 1'b0;
        up_a_data  = {$urandom, $urandom};
        up_a_mask  = 8'($urandom);

        if (rejected) begin
            @(negedge clk_i);
            chk({tag, "_no_beat"}, 64'(dn_a_valid), 64'd0);
        end

        for (int b = 0; b < nb; b++) begin
            @(negedge clk_i);
            chk_beat($sformatf("%s_b%0d", tag, b), op, prm, size, src, addr, mask, data, b);
            dn_a_ready = 1'b0;
            for (int s = 0; s < a_stall; s++) begin
                // A response offered while the beat is still unissued must be ignored.
                dn_d_valid  = 1'b1;
                dn_d_data   = $urandom;
                dn_d_error  = 1'b1;
                dn_d_opcode = 3'($urandom_range(0, 7));
                @(negedge clk_i);
                chk_beat($sformatf("%s_b%0d_stall", tag, b), op, prm, size, src, addr, mask, data, b);
            end
            dn_d_valid = 1'b0;
            dn_d_error = 1'b0;
            dn_a_ready = 1'b1;
            @(posedge clk_i);
            #1;
            dn_a_ready = 1'b0;
            chk($sformatf("%s_b%0d_wait_dready", tag, b), 64'(dn_d_ready), 64'd1);
            chk($sformatf("%s_b%0d_wait_avalid", tag, b), 64'(dn_a_valid), 64'd0);
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) @(negedge clk_i);
            dn_d_valid  = 1'b1;
            dn_d_data   = rd[b];
            dn_d_error  = er[b];
            dn_d_opcode = dop[b];
            @(posedge clk_i);
            #1;
            dn_d_valid = 1'b0;
            dn_d_error = 1'b0;
        end

        if (!rejected) @(negedge clk_i);
        chk_resp({tag, "_resp"}, e_op, size, src, e_data, e_den);
        up_d_ready = 1'b0;
        for (int s = 0; s < d_stall; s++) begin
            @(negedge clk_i);
            chk_resp({tag, "_resp_stall"}, e_op, size, src, e_data, e_den);
            chk({tag, "_resp_stall_avalid"}, 64'(dn_a_valid), 64'd0);
        end
        up_d_ready = 1'b1;
        @(posedge clk_i);
        #1;
        up_d_ready = 1'b0;
        @(negedge clk_i);
        chk_idle_outputs({tag, "_done"});
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [31:0] ad;

        rst_ni       = 1'b0;
        up_a_valid   = 1'b0;
        up_a_opcode  = 3'd0;
        up_a_param   = 3'd0;
        up_a_size    = 3'd0;
        up_a_source  = 8'd0;
        up_a_address = 32'd0;
        up_a_mask    = 8'd0;
        up_a_data    = 64'd0;
        up_d_ready   = 1'b0;
        dn_a_ready   = 1'b0;
        dn_d_valid   = 1'b0;
        dn_d_opcode  = 3'd0;
        dn_d_data    = 32'd0;
        dn_d_error   = 1'b0;

        #2;
        chk_idle_outputs("reset");
        chk("reset_up_d_data", up_d_data, 64'd0);
        chk("reset_dn_a_addr", 64'(dn_a_address), 64'd0);
        chk("reset_dn_a_data", 64'(dn_a_data), 64'd0);
        chk("reset_up_d_denied", 64'(up_d_denied), 64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        run_txn("get8", 3'd4, 3'd0, 3'd3, 8'h5A, 32'h0000_1000, 8'hFF, 64'd0,
                32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0, 0, 0);
        run_txn("put8", 3'd0, 3'd2, 3'd3, 8'h11, 32'h0000_2000, 8'hFF, 64'h1122_3344_5566_7788,
                32'h0, 32'h0, 1'b0, 1'b0, 0, 0);
        run_txn("get4_hi", 3'd4, 3'd0, 3'd2, 8'h22, 32'h0000_2004, 8'hF0, 64'd0,
                32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0, 0, 0);
        run_txn("get4_lo", 3'd4, 3'd0, 3'd2, 8'h23, 32'h0000_3000, 8'h0F, 64'd0,
                32'h1234_5678, 32'h0, 1'b0, 1'b0, 0, 0);
        run_txn("bp", 3'd1, 3'd1, 3'd3, 8'h33, 32'h0000_4008, 8'h3C, 64'h0102_0304_0506_0708,
                32'h0, 32'h0, 1'b0, 1'b0, 5, 3);
        run_txn("err0", 3'd4, 3'd0, 3'd3, 8'h44, 32'h0000_5000, 8'hFF, 64'd0,
                32'h0BAD_0BAD, 32'h600D_600D, 1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 2))
                0:       op = 3'd0;
                1:       op = 3'd1;
                default: op = 3'd4;
            endcase
            sz = 3'($urandom_range(0, 3));
            ad = $urandom & ~((32'd1 << sz) - 32'd1);
            run_txn($sformatf("rnd%0d", i), op, 3'($urandom_range(0, 7)), sz, 8'($urandom), ad,
                    8'($urandom), {$urandom, $urandom}, $urandom, $urandom,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef TLROT_FRAG_ALIGN_CHECK_EN
        run_txn("misalign", 3'd4, 3'd0, 3'd3, 8'h66, 32'h0000_1004, 8'hFF, 64'd0,
                32'h0, 32'h0, 1'b0, 1'b0, 0, 1);
        run_txn("badop", 3'd3, 3'd0, 3'd2, 8'h67, 32'h0000_1004, 8'h0F, 64'd0,
                32'h0, 32'h0, 1'b0, 1'b0, 0, 0);
`endif

        // Reset asserted while waiting for a downstream response.
        up_a_opcode  = 3'd4;
        up_a_param   = 3'd0;
        up_a_size    = 3'd3;
        up_a_source  = 8'h77;
        up_a_address = 32'h0000_6000;
        up_a_mask    = 8'hFF;
        up_a_valid   = 1'b1;
        @(posedge clk_i);
        #1;
        up_a_valid = 1'b0;
        dn_a_ready = 1'b1;
        @(posedge clk_i);
        #1;
        dn_a_ready = 1'b0;
        chk("rst_mid_in_wait", 64'(dn_d_ready), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        chk("rst_mid_up_d_data", up_d_data, 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_after_no_resp", 64'(up_d_valid), 64'd0);
        run_txn("post_rst", 3'd4, 3'd0, 3'd0, 8'h78, 32'h0000_7005, 8'h20, 64'd0,
                32'h0000_00AB, 32'h0, 1'b0, 1'b0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
